dm_store_unit: RTL and testbench
================================

Name: dm_store_unit

Overview:
- Data memory for the MEM stage of the 5-stage MIPS pipeline.
- Holds a word-organised RAM and performs byte, halfword and word stores using byte-lane write enables.
- Supplies the raw, word-aligned read word DMRes plus the low address bits to the downstream load-extension stage in WB, which does byte/half selection and sign extension.
- Flags misaligned and out-of-range accesses.

Parameters:
- ADDR_W, 10, word-address width; RAM depth = 2^ADDR_W words (default 1024 words = 4 KiB).
- BASE, 32'h0000_0000, byte address of word 0; must be 4-byte aligned.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- PC  input  32  PC of the instruction in MEM; used only by the optional write log.
- MemWrite  input  1  store request this cycle.
- MemRead  input  1  load request this cycle; used only for AdEL.
- storeOp  input  6  opcode of the store: SB=6'b101000, SH=6'b101001, SW=6'b101011.
- loadOp  input  6  opcode of the load: LB=6'b100000, LBU=6'b100100, LH=6'b100001, LHU=6'b100101, LW=6'b100011.
- Addr  input  32  byte address computed by the ALU.
- WData  input  32  store data; the byte/half is taken from the low bits.
- DMRes  output  32  word at the word address of Addr; combinational read.
- ByteOff  output  2  Addr[1:0], forwarded to the WB extension stage.
- AdEL  output  1  load address error.
- AdES  output  1  store address error.

Behaviour:
- Index and range:
  - off = Addr - BASE.
  - idx = off[ADDR_W+1:2].
  - inRange = (off[31:ADDR_W+2] == 0).
- Read path:
  - DMRes = inRange ? mem[idx] : 32'h0.
  - Purely combinational; the read occurs in the same cycle as the address.
  - A same-cycle store to the same word is not forwarded; the old word is seen until the next edge.
- Byte enable BE[3:0]:
  - SW: 4'b1111.
  - SH: 4'b0011 if Addr[1]=0, else 4'b1100.
  - SB: 4'b0001 << Addr[1:0].
  - Any other storeOp: 4'b0000.
- Write lanes:
  - SB replicates WData[7:0] to all four lanes.
  - SH replicates WData[15:0] to both halves.
  - SW uses WData unchanged.
  - Only lanes with BE set change.
- Write condition:
  - On posedge clk when reset=1, MemWrite=1, inRange=1, BE!=0 and storeOk=1, each enabled lane is written.
  - Otherwise mem is unchanged.
- Alignment:
  - storeOk=1 for SB.
  - storeOk=1 for SH if Addr[0]=0.
  - storeOk=1 for SW if Addr[1:0]=0.
  - storeOk=0 in all other cases.
  - Misaligned stores never write, with or without the optional feature.
- Reset:
  - reset=0 asynchronously clears every mem word to 0; a write coinciding with reset assertion is dropped.
  - During reset, DMRes=0 for in-range addresses.
  - During reset, ByteOff follows Addr[1:0], and AdEL/AdES=0.
  - Deassertion takes effect at the next edge with no extra latency.
- Latency:
  - Store: 1 cycle; data is visible on DMRes in the cycle after the write edge.
  - Load: 0 cycles (combinational).
- Both MemWrite and MemRead high in one cycle: illegal from the decoder. The store still executes; DMRes shows the pre-store value.
- ByteOff = Addr[1:0], always.

Optional Feature:
- Macro: DM_ADDR_EXC_EN.
- With the macro defined:
  - AdES=1 when MemWrite=1 and (storeOk=0 or inRange=0 or BE=0).
  - AdEL=1 when MemRead=1 and (inRange=0, or LW with Addr[1:0]!=0, or LH/LHU with Addr[0]=1).
  - Both are combinational and forced to 0 while reset=0.
- Without the macro: AdEL and AdES are tied to 0. Write suppression on misalignment or out-of-range is unchanged.

Test Plan:
- Reset, then Addr=0x10, MemRead=1 -> DMRes=0x00000000; AdEL=0, AdES=0.
- SW WData=0x12345678 to 0x10, then SB WData=0xAB to 0x11 -> at 0x10, DMRes=0x1234AB78; ByteOff=2'b01 for an access at 0x11.
- SH WData=0xBEEF to 0x12 over the word 0x1234AB78 -> DMRes=0xBEEFAB78.
- SW WData=0xFFFFFFFF to 0x13 -> memory unchanged; AdES=1 only when DM_ADDR_EXC_EN is defined.
- SW to 0x1000 with ADDR_W=10 -> no write, DMRes=0; AdES=1 with the feature. LH at 0x11 -> AdEL=1 with the feature.
- Issue SW 0xCAFEF00D at 0x20, drive reset=0 mid-cycle before the edge, release reset -> DMRes at 0x20 = 0, with no clock edge needed for the clear.

Source files
------------

// File: rtl/dm_store_unit_if.sv
// dm_store_unit_if
//   Bus between the MEM stage and the data memory.
//   master : pipeline side (drives PC, MemWrite, MemRead, storeOp, loadOp,
//            Addr, WData; receives DMRes, ByteOff, AdEL, AdES)
//   slave  : data memory side
interface dm_store_unit_if;
    logic [31:0] PC;
    logic        MemWrite;
    logic        MemRead;
    logic [5:0]  storeOp;
    logic [5:0]  loadOp;
    logic [31:0] Addr;
    logic [31:0] WData;
    logic [31:0] DMRes;
    logic [1:0]  ByteOff;
    logic        AdEL;
    logic        AdES;

    modport master (
        output PC, MemWrite, MemRead, storeOp, loadOp, Addr, WData,
        input  DMRes, ByteOff, AdEL, AdES
    );

    modport slave (
        input  PC, MemWrite, MemRead, storeOp, loadOp, Addr, WData,
        output DMRes, ByteOff, AdEL, AdES
    );
endinterface

// File: rtl/dm_store_unit.sv
// dm_store_unit
//   MEM-stage data memory: word-organised RAM with byte-lane stores
//   (SB/SH/SW), combinational word-aligned read, and address error flags.
//   Byte/half selection and sign extension of loads happen downstream in WB.
// Ports
//   clk    : system clock, rising edge
//   reset  : asynchronous active-low reset; clears the whole RAM
//   bus    : dm_store_unit_if.slave (PC, MemWrite, MemRead, storeOp, loadOp,
//            Addr, WData in; DMRes, ByteOff, AdEL, AdES out)
// Optional feature
//   DM_ADDR_EXC_EN : when defined, AdEL/AdES report misaligned, out-of-range
//                    and invalid-opcode accesses; otherwise both are 0.
//                    Bad stores are suppressed either way.
module dm_store_unit #(
    parameter int          ADDR_W = 10,
    parameter logic [31:0] BASE   = 32'h0000_0000
) (
    input logic             clk,
    input logic             reset,
    dm_store_unit_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LW  = 6'b100011;

    logic [31:0]       mem [DEPTH];
    logic [31:0]       off;
    logic [ADDR_W-1:0] idx;
    logic              in_range;
    logic [3:0]        be;
    logic [31:0]       wdata_rep;
    logic              store_ok;
    logic              we;

    assign off      = bus.Addr - BASE;
    assign idx      = off[ADDR_W+1:2];
    assign in_range = (off[31:ADDR_W+2] == '0);

    // Lane enables and lane-replicated store data; the replication lets a
    // single enable mask pick the right byte/half regardless of offset.
    always_comb begin
        be        = 4'b0000;
        wdata_rep = bus.WData;
        store_ok  = 1'b0;
        case (bus.storeOp)
            OP_SB: begin
                be        = 4'b0001 << bus.Addr[1:0];
                wdata_rep = {4{bus.WData[7:0]}};
                store_ok  = 1'b1;
            end
            OP_SH: begin
                be        = bus.Addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{bus.WData[15:0]}};
                store_ok  = ~bus.Addr[0];
            end
            OP_SW: begin
                be        = 4'b1111;
                wdata_rep = bus.WData;
                store_ok  = (bus.Addr[1:0] == 2'b00);
            end
            default: ;
        endcase
    end

    assign we = bus.MemWrite & in_range & (be != 4'b0000) & store_ok;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
                end
            end
        end
    end

    // No store forwarding: a same-cycle store shows up after the edge.
    assign bus.DMRes   = in_range ? mem[idx] : 32'h0000_0000;
    assign bus.ByteOff = bus.Addr[1:0];

`ifdef DM_ADDR_EXC_EN
    logic ades;
    logic adel;

    always_comb begin
        ades = 1'b0;
        adel = 1'b0;
        if (reset) begin
            ades = bus.MemWrite & (~store_ok | ~in_range | (be == 4'b0000));
            adel = bus.MemRead &
                   (~in_range |
                    ((bus.loadOp == OP_LW) && (bus.Addr[1:0] != 2'b00)) |
                    (((bus.loadOp == OP_LH) || (bus.loadOp == OP_LHU)) && bus.Addr[0]));
        end
    end

    assign bus.AdES = ades;
    assign bus.AdEL = adel;
`else
    assign bus.AdES = 1'b0;
    assign bus.AdEL = 1'b0;
`endif

    // PC only feeds an external write log; low offset bits are carried by ByteOff.
    logic unused_sink;
    assign unused_sink = ^{bus.PC, bus.loadOp, bus.MemRead, off[1:0]};

endmodule

// File: tb/tb_dm_store_unit.sv
module tb_dm_store_unit;
    localparam logic [5:0] SB  = 6'b101000;
    localparam logic [5:0] SH  = 6'b101001;
    localparam logic [5:0] SW  = 6'b101011;
    localparam logic [5:0] LH  = 6'b100001;
    localparam logic [5:0] LW  = 6'b100011;
`ifdef DM_ADDR_EXC_EN
    localparam logic EXC = 1'b1;
`else
    localparam logic EXC = 1'b0;
`endif

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    dm_store_unit_if bus ();

    dm_store_unit #(.ADDR_W(10), .BASE(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a store at the falling edge; outputs are sampled 1 time unit later.
    task automatic store_issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.MemWrite = 1'b1;
        bus.MemRead  = 1'b0;
        bus.storeOp  = op;
        bus.Addr     = a;
        bus.WData    = d;
        #1;
    endtask

    task automatic store_commit();
        @(posedge clk);
        #1;
        bus.MemWrite = 1'b0;
        bus.storeOp  = 6'b000000;
    endtask

    task automatic read_at(input logic [5:0] op, input logic [31:0] a);
        @(negedge clk);
        bus.MemWrite = 1'b0;
        bus.MemRead  = 1'b1;
        bus.loadOp   = op;
        bus.Addr     = a;
        #1;
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        bus.PC       = 32'h0040_0000;
        bus.MemWrite = 1'b0;
        bus.MemRead  = 1'b1;
        bus.storeOp  = 6'b000000;
        bus.loadOp   = LW;
        bus.Addr     = 32'h10;
        bus.WData    = 32'h0;
        #1;
        checks++; if (bus.DMRes !== 32'h0) begin failures++; $display("FAIL reset_dmres got=%h exp=%h", bus.DMRes, 32'h0); end
        checks++; if (bus.AdEL !== 1'b0) begin failures++; $display("FAIL reset_adel got=%b exp=0", bus.AdEL); end
        checks++; if (bus.AdES !== 1'b0) begin failures++; $display("FAIL reset_ades got=%b exp=0", bus.AdES); end
        bus.Addr = 32'h13;
        #1;
        checks++; if (bus.ByteOff !== 2'b11) begin failures++; $display("FAIL reset_byteoff got=%b exp=11", bus.ByteOff); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_sw_sb();
        store_issue(SW, 32'h10, 32'h1234_5678);
        checks++; if (bus.DMRes !== 32'h0) begin failures++; $display("FAIL no_forward got=%h exp=%h", bus.DMRes, 32'h0); end
        checks++; if (bus.AdES !== 1'b0) begin failures++; $display("FAIL sw_ades got=%b exp=0", bus.AdES); end
        store_commit();
        read_at(LW, 32'h10);
        checks++; if (bus.DMRes !== 32'h1234_5678) begin failures++; $display("FAIL sw_word got=%h exp=%h", bus.DMRes, 32'h1234_5678); end
        store_issue(SB, 32'h11, 32'h0000_00AB);
        store_commit();
        read_at(LW, 32'h11);
        checks++; if (bus.DMRes !== 32'h1234_AB78) begin failures++; $display("FAIL sb_lane1 got=%h exp=%h", bus.DMRes, 32'h1234_AB78); end
        checks++; if (bus.ByteOff !== 2'b01) begin failures++; $display("FAIL byteoff_11 got=%b exp=01", bus.ByteOff); end
    endtask

    task automatic test_sh();
        store_issue(SH, 32'h12, 32'h0000_BEEF);
        store_commit();
        read_at(LW, 32'h10);
        checks++; if (bus.DMRes !== 32'hBEEF_AB78) begin failures++; $display("FAIL sh_upper got=%h exp=%h", bus.DMRes, 32'hBEEF_AB78); end
        store_issue(SH, 32'h10, 32'hFFFF_1111);
        store_commit();
        read_at(LW, 32'h10);
        checks++; if (bus.DMRes !== 32'hBEEF_1111) begin failures++; $display("FAIL sh_lower got=%h exp=%h", bus.DMRes, 32'hBEEF_1111); end
        store_issue(SB, 32'h13, 32'h0000_00CD);
        store_commit();
        read_at(LW, 32'h10);
        checks++; if (bus.DMRes !== 32'hCDEF_1111) begin failures++; $display("FAIL sb_lane3 got=%h exp=%h", bus.DMRes, 32'hCDEF_1111); end
    endtask

    task automatic test_misaligned();
        store_issue(SW, 32'h13, 32'hFFFF_FFFF);
        checks++; if (bus.AdES !== EXC) begin failures++; $display("FAIL sw_mis_ades got=%b exp=%b", bus.AdES, EXC); end
        store_commit();
        store_issue(SH, 32'h11, 32'hFFFF_FFFF);
        checks++; if (bus.AdES !== EXC) begin failures++; $display("FAIL sh_mis_ades got=%b exp=%b", bus.AdES, EXC); end
        store_commit();
        store_issue(LW, 32'h10, 32'hFFFF_FFFF);
        checks++; if (bus.AdES !== EXC) begin failures++; $display("FAIL badop_ades got=%b exp=%b", bus.AdES, EXC); end
        store_commit();
        read_at(LW, 32'h10);
        checks++; if (bus.DMRes !== 32'hCDEF_1111) begin failures++; $display("FAIL mis_nowrite got=%h exp=%h", bus.DMRes, 32'hCDEF_1111); end
        read_at(LH, 32'h11);
        checks++; if (bus.AdEL !== EXC) begin failures++; $display("FAIL lh_mis_adel got=%b exp=%b", bus.AdEL, EXC); end
        read_at(LW, 32'h12);
        checks++; if (bus.AdEL !== EXC) begin failures++; $display("FAIL lw_mis_adel got=%b exp=%b", bus.AdEL, EXC); end
        read_at(LH, 32'h12);
        checks++; if (bus.AdEL !== 1'b0) begin failures++; $display("FAIL lh_ok_adel got=%b exp=0", bus.AdEL); end
    endtask

    task automatic test_out_of_range();
        store_issue(SW, 32'h1000, 32'hDEAD_BEEF);
        checks++; if (bus.AdES !== EXC) begin failures++; $display("FAIL oor_ades got=%b exp=%b", bus.AdES, EXC); end
        store_commit();
        read_at(LW, 32'h1000);
        checks++; if (bus.DMRes !== 32'h0) begin failures++; $display("FAIL oor_dmres got=%h exp=%h", bus.DMRes, 32'h0); end
        checks++; if (bus.AdEL !== EXC) begin failures++; $display("FAIL oor_adel got=%b exp=%b", bus.AdEL, EXC); end
        read_at(LW, 32'h0);
        checks++; if (bus.DMRes !== 32'h0) begin failures++; $display("FAIL oor_alias got=%h exp=%h", bus.DMRes, 32'h0); end
        read_at(LW, 32'hFFC);
        checks++; if (bus.DMRes !== 32'h0) begin failures++; $display("FAIL top_word got=%h exp=%h", bus.DMRes, 32'h0); end
        checks++; if (bus.AdEL !== 1'b0) begin failures++; $display("FAIL top_adel got=%b exp=0", bus.AdEL); end
    endtask

    task automatic test_back_to_back();
        store_issue(SW, 32'h20, 32'h1111_2222);
        store_commit();
        bus.MemWrite = 1'b1;
        bus.storeOp  = SW;
        bus.Addr     = 32'h24;
        bus.WData    = 32'h3333_4444;
        store_commit();
        // store and load in one cycle: store lands, read shows old word
        store_issue(SW, 32'h20, 32'h5555_6666);
        bus.MemRead = 1'b1;
        bus.loadOp  = LW;
        #1;
        checks++; if (bus.DMRes !== 32'h1111_2222) begin failures++; $display("FAIL rw_old got=%h exp=%h", bus.DMRes, 32'h1111_2222); end
        store_commit();
        read_at(LW, 32'h20);
        checks++; if (bus.DMRes !== 32'h5555_6666) begin failures++; $display("FAIL rw_new got=%h exp=%h", bus.DMRes, 32'h5555_6666); end
        read_at(LW, 32'h24);
        checks++; if (bus.DMRes !== 32'h3333_4444) begin failures++; $display("FAIL b2b_24 got=%h exp=%h", bus.DMRes, 32'h3333_4444); end
    endtask

    task automatic test_reset_clear();
        store_issue(SW, 32'h20, 32'hCAFE_F00D);
        checks++; if (bus.DMRes !== 32'h5555_6666) begin failures++; $display("FAIL pre_rst got=%h exp=%h", bus.DMRes, 32'h5555_6666); end
        #1;
        reset = 1'b0;
        #1;
        checks++; if (bus.DMRes !== 32'h0) begin failures++; $display("FAIL async_clr20 got=%h exp=%h", bus.DMRes, 32'h0); end
        checks++; if (bus.AdES !== 1'b0) begin failures++; $display("FAIL rst_ades got=%b exp=0", bus.AdES); end
        bus.Addr = 32'h24;
        #1;
        checks++; if (bus.DMRes !== 32'h0) begin failures++; $display("FAIL async_clr24 got=%h exp=%h", bus.DMRes, 32'h0); end
        bus.Addr = 32'h20;
        @(posedge clk);
        @(negedge clk);
        bus.MemWrite = 1'b0;
        reset        = 1'b1;
        read_at(LW, 32'h20);
        checks++; if (bus.DMRes !== 32'h0) begin failures++; $display("FAIL rst_drop_wr got=%h exp=%h", bus.DMRes, 32'h0); end
        store_issue(SW, 32'h20, 32'hCAFE_F00D);
        store_commit();
        read_at(LW, 32'h20);
        checks++; if (bus.DMRes !== 32'hCAFE_F00D) begin failures++; $display("FAIL post_rst_wr got=%h exp=%h", bus.DMRes, 32'hCAFE_F00D); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_sw_sb();
        test_sh();
        test_misaligned();
        test_out_of_range();
        test_back_to_back();
        test_reset_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
